neural_soc_from_hw_sig: RTL and testbench
=========================================

NEURAL_SOC_FROM_HW_SIG -- requirements
Module: neural_soc_from_hw_sig

Interface
REQ-001 Parameter WIDTH, default 2: number of input bits, 1..32.
REQ-002 Parameter EDGE_TYPE, default 0: edge type to capture. 0 = rising, 1 = falling, 2 = any.
REQ-003 Port clk, input, 1: single clock; all state SHALL update on its rising edge.
REQ-004 Port reset_n, input, 1: reset, synchronous and active-low.
REQ-005 Port address, input, 2: Avalon-MM slave register select.
REQ-006 Port chipselect, input, 1: slave access qualifier.
REQ-007 Port write_n, input, 1: active-low write strobe.
REQ-008 Port writedata, input, 32: write data.
REQ-009 Port in_port, input, WIDTH: asynchronous hardware status bits from the neural core.
REQ-010 Port readdata, output, 32: read data, zero-wait-state.
REQ-011 Port irq, output, 1: level interrupt to the processor.

Function
REQ-012 in_port SHALL pass through a two-flop synchronizer (sync1, then sync2) before any other use.
REQ-013 A change on in_port SHALL become visible at address 0 after exactly 2 clk edges.
REQ-014 Register prev SHALL load sync2 every cycle.
  - Rising edge: sync2 & ~prev.
  - Falling edge: ~sync2 & prev.
  - Any edge: sync2 ^ prev.
REQ-015 Edge capture SHALL be sticky. A detected edge sets its edgecapture bit on the next clk edge, so the bit is visible 3 cycles after the in_port change.
REQ-016 Register map, read side, with readdata combinational from address and the current registers:
  - Address 0: data, zero-extended sync2, read-only.
  - Address 1: reads 0.
  - Address 2: irqmask, read/write.
  - Address 3: edgecapture, read / write-1-to-clear.
REQ-017 Write qualifier is chipselect & ~write_n.
  - A write to address 2 SHALL load irqmask from writedata[WIDTH-1:0].
  - A write to address 3 SHALL clear each edgecapture bit whose writedata bit is 1.
  - Writes to addresses 0 and 1 SHALL be ignored.
REQ-018 If a bit's edge detection and its clear occur in the same cycle, the set SHALL win and the bit SHALL stay 1.
REQ-019 Reads SHALL have no side effects.
REQ-020 irq SHALL equal |(edgecapture & irqmask). It is combinational from registers, so irq asserts in the same cycle edgecapture or irqmask changes.
REQ-021 A settle counter (0..3) SHALL suppress edge detection for the first 3 cycles after reset_n returns high. This stops a static-high input from producing a spurious edge.

Reset
REQ-022 While reset_n is 0 at a clk edge, the following SHALL be cleared to 0: sync1, sync2, prev, edgecapture, irqmask and the settle counter.
REQ-023 During reset, readdata SHALL follow the cleared registers and irq SHALL be 0.
REQ-024 Reset asserted mid-operation SHALL discard pending captures; no edge SHALL be lost to or invented by reset except as REQ-021 states.

Configuration
REQ-025 Macro NEURAL_SOC_FROM_HW_SIG_IRQ_EN controls interrupt support.
  - Defined: irqmask register and irq generation are present, as specified above.
  - Undefined: irqmask is not implemented, address 2 reads 0, writes to address 2 are ignored, and irq is tied to 0.
  - Edge capture SHALL remain functional in both builds.

Structure
REQ-026 Package neural_soc_pio_pkg SHALL hold the following, shared with the output PIO:
  - Register address constants ADDR_DATA=0, ADDR_DIR=1, ADDR_IRQMASK=2, ADDR_EDGECAP=3.
  - EDGE_TYPE encodings EDGE_RISE, EDGE_FALL, EDGE_ANY.
REQ-027 One sub-module, neural_soc_sync2, SHALL implement the two-flop synchronizer with WIDTH parameter and synchronous active-low reset. It SHALL be instantiated once.

Verification
REQ-028 Latency: hold reset 4 cycles, release, drive in_port=2'b01 at cycle 10.
  - Address 0 reads 0x1 from cycle 12.
  - Address 3 reads 0x1 from cycle 13.
REQ-029 Settle suppression: in_port=2'b11 throughout reset and release. Address 3 stays 0x0 for 20 cycles.
REQ-030 Sticky capture and interrupt: write 0x3 to address 2, pulse in_port[1] high for 1 cycle.
  - Address 3 reads 0x2 and irq=1 and stays 1.
  - Write 0x2 to address 3: address 3 reads 0x0 and irq=0 on the next cycle.
REQ-031 Set-over-clear: write 0x1 to address 3 in the same cycle a rising edge of bit 0 is detected. Address 3 reads 0x1 afterwards.
REQ-032 Masking and configuration:
  - irqmask=0x0 with edgecapture=0x3: irq=0.
  - Macro undefined: write 0x3 to address 2, which reads 0x0, and irq stays 0 after edges.
REQ-033 EDGE_TYPE=2: toggle in_port[0] 0→1→0. Each transition sets bit 0; after one clear, the second edge sets it again.

Source files
------------

// File: rtl/neural_soc_from_hw_sig_pkg.sv
// Constants shared by the neural SoC PIO blocks: register map and edge-type codes.
package neural_soc_pio_pkg;

  // Avalon-MM register addresses
  localparam logic [1:0] ADDR_DATA    = 2'd0;
  localparam logic [1:0] ADDR_DIR     = 2'd1;
  localparam logic [1:0] ADDR_IRQMASK = 2'd2;
  localparam logic [1:0] ADDR_EDGECAP = 2'd3;

  // EDGE_TYPE parameter encodings
  localparam int EDGE_RISE = 0;
  localparam int EDGE_FALL = 1;
  localparam int EDGE_ANY  = 2;

  // Settle counter terminal value: edge detection is enabled once it is reached
  localparam logic [1:0] SETTLE_DONE = 2'd3;

endpackage

// File: rtl/neural_soc_from_hw_sig_if.sv
// Avalon-MM slave bus for the neural SoC PIO; the processor side is the master.
interface neural_soc_from_hw_sig_if;

  logic [1:0]  address;
  logic        chipselect;
  logic        write_n;
  logic [31:0] writedata;
  logic [31:0] readdata;

  modport master (
    output address, chipselect, write_n, writedata,
    input  readdata
  );

  modport slave (
    input  address, chipselect, write_n, writedata,
    output readdata
  );

endinterface

// File: rtl/neural_soc_from_hw_sig_sync2.sv
// Two-flop synchronizer bringing asynchronous status bits into the clk domain.
module neural_soc_sync2 #(
  parameter int WIDTH = 2
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [WIDTH-1:0] i_d,
  output logic [WIDTH-1:0] o_q
);

  logic [WIDTH-1:0] r_sync1;
  logic [WIDTH-1:0] r_sync2;

  // Shift the raw input through sync1 then sync2; both clear in reset.
  // NOTE: non-blocking assignments make both flops sample old values, forming a real two-stage chain.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_sync1 <= '0;
      r_sync2 <= '0;
    end else begin
      r_sync1 <= i_d;
      r_sync2 <= r_sync1;
    end
  end

  assign o_q = r_sync2;

endmodule

// File: rtl/neural_soc_from_hw_sig.sv
// Input PIO for neural-core status bits: synchronized data, sticky edge capture,
// optional masked level interrupt. Interrupt support is built only when the
// macro NEURAL_SOC_FROM_HW_SIG_IRQ_EN is defined; otherwise irqmask is absent
// and irq is tied low.
module neural_soc_from_hw_sig
  import neural_soc_pio_pkg::*;
#(
  parameter int WIDTH     = 2,
  parameter int EDGE_TYPE = EDGE_RISE
) (
  input  logic                     clk,
  input  logic                     reset_n,
  neural_soc_from_hw_sig_if.slave  bus,
  input  logic [WIDTH-1:0]         in_port,
  output logic                     irq
);

  logic [WIDTH-1:0] w_sync2;
  logic [WIDTH-1:0] r_prev;
  logic [WIDTH-1:0] r_edgecap;
  logic [WIDTH-1:0] w_edge;
  logic [WIDTH-1:0] w_edge_det;
  logic [WIDTH-1:0] w_clear;
  logic [WIDTH-1:0] w_mask_rd;
  logic [1:0]       r_settle;
  logic             w_wr;
  logic [31:0]      w_rdata;

  neural_soc_sync2 #(.WIDTH(WIDTH)) u_sync2 (
    .clk     (clk),
    .reset_n (reset_n),
    .i_d     (in_port),
    .o_q     (w_sync2)
  );

  assign w_wr    = bus.chipselect & ~bus.write_n;
  assign w_clear = (w_wr && bus.address == ADDR_EDGECAP) ? bus.writedata[WIDTH-1:0] : '0;

  // Upper write-data bits carry nothing for narrow configurations.
  if (WIDTH < 32) begin : g_wdata_unused
    logic w_unused_wdata;
    assign w_unused_wdata = ^bus.writedata[31:WIDTH];
  end

  // Track previous synchronized value and count settle cycles after reset release.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_prev   <= '0;
      r_settle <= '0;
    end else begin
      r_prev <= w_sync2;
      if (r_settle != SETTLE_DONE) r_settle <= r_settle + 2'd1;
    end
  end

  // Select the configured edge polarity.
  // NOTE: every always_comb output gets a value on every path (here via default) so no latch is inferred.
  always_comb begin
    case (EDGE_TYPE)
      EDGE_FALL: w_edge = ~w_sync2 & r_prev;
      EDGE_ANY:  w_edge = w_sync2 ^ r_prev;
      default:   w_edge = w_sync2 & ~r_prev;
    endcase
  end

  // Until the synchronizer and prev have filled with real input, the zeroed
  // pipeline would look like an edge on any bit that is already high.
  assign w_edge_det = (r_settle == SETTLE_DONE) ? w_edge : '0;

  // Sticky capture with write-1-to-clear; a new edge beats a simultaneous clear.
  always_ff @(posedge clk) begin
    if (!reset_n) r_edgecap <= '0;
    else          r_edgecap <= (r_edgecap & ~w_clear) | w_edge_det;
  end

`ifdef NEURAL_SOC_FROM_HW_SIG_IRQ_EN
  logic [WIDTH-1:0] r_irqmask;

  // Interrupt mask register, loaded by writes to the mask address.
  always_ff @(posedge clk) begin
    if (!reset_n)                                  r_irqmask <= '0;
    else if (w_wr && bus.address == ADDR_IRQMASK)  r_irqmask <= bus.writedata[WIDTH-1:0];
  end

  assign w_mask_rd = r_irqmask;
  assign irq       = |(r_edgecap & r_irqmask);
`else
  assign w_mask_rd = '0;
  assign irq       = 1'b0;
`endif

  // Zero-wait-state read mux; reads never alter state.
  always_comb begin
    w_rdata = '0;
    case (bus.address)
      ADDR_DATA:    w_rdata[WIDTH-1:0] = w_sync2;
      ADDR_IRQMASK: w_rdata[WIDTH-1:0] = w_mask_rd;
      ADDR_EDGECAP: w_rdata[WIDTH-1:0] = r_edgecap;
      default:      w_rdata = '0;
    endcase
  end

  assign bus.readdata = w_rdata;

endmodule

// File: tb/tb_neural_soc_from_hw_sig.sv
// Scoreboard bench: three instances (rising, falling, any edge) share one
// stimulus stream; a reference model predicts each read, a monitor compares.
module tb_neural_soc_from_hw_sig;
  import neural_soc_pio_pkg::*;

`ifdef NEURAL_SOC_FROM_HW_SIG_IRQ_EN
  localparam bit IRQ_EN = 1'b1;
`else
  localparam bit IRQ_EN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset_n;
  logic [1:0]  in_port;
  logic [1:0]  address;
  logic        chipselect;
  logic        write_n;
  logic [31:0] writedata;
  logic [2:0]  irq;

  always #5 clk = ~clk;

  neural_soc_from_hw_sig_if bus_r ();
  neural_soc_from_hw_sig_if bus_f ();
  neural_soc_from_hw_sig_if bus_a ();

  assign bus_r.address = address;    assign bus_f.address = address;    assign bus_a.address = address;
  assign bus_r.chipselect = chipselect; assign bus_f.chipselect = chipselect; assign bus_a.chipselect = chipselect;
  assign bus_r.write_n = write_n;    assign bus_f.write_n = write_n;    assign bus_a.write_n = write_n;
  assign bus_r.writedata = writedata; assign bus_f.writedata = writedata; assign bus_a.writedata = writedata;

  neural_soc_from_hw_sig #(.WIDTH(2), .EDGE_TYPE(EDGE_RISE)) u_rise (
    .clk(clk), .reset_n(reset_n), .bus(bus_r.slave), .in_port(in_port), .irq(irq[0]));
  neural_soc_from_hw_sig #(.WIDTH(2), .EDGE_TYPE(EDGE_FALL)) u_fall (
    .clk(clk), .reset_n(reset_n), .bus(bus_f.slave), .in_port(in_port), .irq(irq[1]));
  neural_soc_from_hw_sig #(.WIDTH(2), .EDGE_TYPE(EDGE_ANY)) u_any (
    .clk(clk), .reset_n(reset_n), .bus(bus_a.slave), .in_port(in_port), .irq(irq[2]));

  typedef struct packed {
    logic [1:0]       addr;
    logic [2:0][31:0] rd;
    logic [2:0]       irq;
  } exp_t;

  exp_t exp_q[$];
  int   n_cmp = 0;
  int   n_bad = 0;

  // Reference model: what in_port looked like at recent clock edges (newest
  // first), edges since reset release, and per-instance captured/mask bits.
  logic [1:0] hist[4];
  int         run_len;
  logic [1:0] cap[3];
  logic [1:0] mask;

  function automatic logic [1:0] edges_of(input int kind, input logic [1:0] now_v, input logic [1:0] was_v);
    case (kind)
      0:       return now_v & ~was_v;
      1:       return ~now_v & was_v;
      default: return now_v ^ was_v;
    endcase
  endfunction

  // Apply one clock edge's worth of behaviour to the model.
  task automatic model_edge(input logic rst_n, input logic [1:0] inp, input logic [1:0] a,
                            input logic wr, input logic [31:0] wd);
    logic [1:0] clr;
    if (!rst_n) begin
      for (int i = 0; i < 4; i++) hist[i] = 2'b00;
      for (int t = 0; t < 3; t++) cap[t] = 2'b00;
      mask    = 2'b00;
      run_len = 0;
    end else begin
      run_len++;
      hist[3] = hist[2]; hist[2] = hist[1]; hist[1] = hist[0]; hist[0] = inp;
      clr = (wr && a == 2'd3) ? wd[1:0] : 2'b00;
      // The value seen at address 0 two edges ago vs. three edges ago
      // forms the edge that lands now; ignored during the first 3 edges.
      for (int t = 0; t < 3; t++)
        cap[t] = (cap[t] & ~clr) | ((run_len >= 4) ? edges_of(t, hist[2], hist[3]) : 2'b00);
      if (IRQ_EN && wr && a == 2'd2) mask = wd[1:0];
    end
  endtask

  function automatic exp_t predict(input logic [1:0] a);
    exp_t e;
    e.addr = a;
    for (int t = 0; t < 3; t++) begin
      case (a)
        2'd0:    e.rd[t] = {30'd0, hist[1]};
        2'd2:    e.rd[t] = {30'd0, mask};
        2'd3:    e.rd[t] = {30'd0, cap[t]};
        default: e.rd[t] = 32'd0;
      endcase
      e.irq[t] = IRQ_EN ? |(cap[t] & mask) : 1'b0;
    end
    return e;
  endfunction

  // Present one cycle of inputs, queue the expected read response, then step the model.
  task automatic cycle(input logic rst_n, input logic [1:0] inp, input logic [1:0] a,
                       input logic wr, input logic [31:0] wd);
    reset_n    = rst_n;
    in_port    = inp;
    address    = a;
    chipselect = 1'b1;
    write_n    = ~wr;
    writedata  = wd;
    if (!wr) exp_q.push_back(predict(a));
    @(posedge clk); #1;
    model_edge(rst_n, inp, a, wr, wd);
  endtask

  task automatic rd(input logic [1:0] inp, input logic [1:0] a);
    cycle(1'b1, inp, a, 1'b0, 32'd0);
  endtask

  task automatic wr(input logic [1:0] inp, input logic [1:0] a, input logic [31:0] d);
    cycle(1'b1, inp, a, 1'b1, d);
  endtask

  task automatic rst(input logic [1:0] inp, input int n);
    for (int i = 0; i < n; i++) cycle(1'b0, inp, 2'd3, 1'b0, 32'd0);
  endtask

  // Monitor: on every read cycle pop the oldest prediction and compare all instances.
  initial begin
    exp_t e;
    logic [2:0][31:0] got;
    forever begin
      @(negedge clk);
      if (chipselect && write_n) begin
        got[0] = bus_r.readdata; got[1] = bus_f.readdata; got[2] = bus_a.readdata;
        if (exp_q.size() == 0) begin
          n_cmp++; n_bad++;
          $display("FAIL scoreboard_empty: read seen at %0t with nothing expected", $time);
        end else begin
          e = exp_q.pop_front();
          for (int t = 0; t < 3; t++) begin
            n_cmp++;
            if (got[t] !== e.rd[t] || irq[t] !== e.irq[t]) begin
              n_bad++;
              $display("FAIL read_dut%0d addr%0d at %0t: got rd=%h irq=%b, expected rd=%h irq=%b",
                       t, e.addr, $time, got[t], irq[t], e.rd[t], e.irq[t]);
            end
          end
        end
      end
    end
  end

  initial begin
    logic [1:0] inp;
    int         r;
    reset_n = 1'b0; in_port = 2'b00; address = 2'd0; chipselect = 1'b0;
    write_n = 1'b1; writedata = 32'd0;
    @(posedge clk); #1;
    model_edge(1'b0, 2'b00, 2'd0, 1'b0, 32'd0);

    // Latency: 4 reset cycles, in_port=01 from cycle 10; watch address 0 then address 3.
    for (int k = 0; k < 2; k++) begin
      rst(2'b00, 4);
      for (int c = 5; c <= 9; c++) rd(2'b00, (k == 0) ? 2'd0 : 2'd3);
      for (int c = 10; c <= 16; c++) rd(2'b01, (k == 0) ? 2'd0 : 2'd3);
    end

    // Settle suppression: input high through reset and release.
    rst(2'b11, 4);
    for (int c = 0; c < 20; c++) rd(2'b11, 2'd3);

    // Sticky capture and interrupt, then write-1-to-clear.
    rst(2'b00, 4);
    for (int c = 0; c < 6; c++) rd(2'b00, 2'd3);
    wr(2'b00, 2'd2, 32'h3);
    rd(2'b10, 2'd2);
    for (int c = 0; c < 6; c++) rd(2'b00, 2'd3);
    wr(2'b00, 2'd3, 32'h2);
    for (int c = 0; c < 3; c++) rd(2'b00, 2'd3);

    // Set wins over a clear landing on the same edge.
    rd(2'b01, 2'd3);
    rd(2'b01, 2'd3);
    wr(2'b01, 2'd3, 32'h1);
    for (int c = 0; c < 3; c++) rd(2'b01, 2'd3);

    // Toggle bit 0 down and back up with a clear in between.
    wr(2'b01, 2'd3, 32'h3);
    for (int c = 0; c < 4; c++) rd(2'b00, 2'd3);
    wr(2'b00, 2'd3, 32'h1);
    for (int c = 0; c < 4; c++) rd(2'b01, 2'd3);

    // Mask of zero hides captured edges from irq.
    wr(2'b01, 2'd2, 32'h0);
    wr(2'b01, 2'd3, 32'h3);
    for (int c = 0; c < 4; c++) rd(2'b00, 2'd3);
    for (int c = 0; c < 4; c++) rd(2'b11, 2'd3);
    rd(2'b11, 2'd1);
    wr(2'b11, 2'd0, 32'hFFFF_FFFF);
    wr(2'b11, 2'd1, 32'hFFFF_FFFF);
    rd(2'b11, 2'd0);
    rd(2'b11, 2'd2);

    // Randomized traffic with occasional mid-run resets.
    inp = 2'b00;
    for (int c = 0; c < 3000; c++) begin
      if ($urandom_range(0, 9) < 3) inp = 2'($urandom);
      r = $urandom_range(0, 99);
      if (r < 2)       rst(inp, 1);
      else if (r < 12) wr(inp, 2'($urandom_range(2, 3)), $urandom);
      else if (r < 16) wr(inp, 2'($urandom_range(0, 1)), $urandom);
      else             rd(inp, 2'($urandom));
    end

    chipselect = 1'b0;
    repeat (2) @(negedge clk);
    n_cmp++;
    if (exp_q.size() != 0) begin
      n_bad++;
      $display("FAIL scoreboard_drain: %0d reads left unchecked, expected 0", exp_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
